// File: rtl/mem_write_checker_if.sv
// Signal bundle for mem_write_checker: expected-table load port, run control,
// observed CPU store port and the status/diagnostic outputs.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_EXP  = 4,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1;

  logic              exp_we;
  logic [IDX_W-1:0]  exp_idx;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              ordered;
  logic              start;
  logic              clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              pass;
  logic              fail;
  logic              timed_out;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [ADDR_W-1:0] bad_addr;
  logic [DATA_W-1:0] bad_data;

  modport master (
    output exp_we, exp_idx, exp_addr, exp_data, ordered, start, clear,
           mem_we, mem_addr, mem_wdata,
    input  busy, pass, fail, timed_out, match_cnt, mismatch_cnt, bad_addr, bad_data
  );

  modport slave (
    input  exp_we, exp_idx, exp_addr, exp_data, ordered, start, clear,
           mem_we, mem_addr, mem_wdata,
    output busy, pass, fail, timed_out, match_cnt, mismatch_cnt, bad_addr, bad_data
  );
endinterface

// File: rtl/mem_write_checker.sv
// Data-memory write checker: matches CPU stores against a table of expected writes.
// Define CHECKER_STRICT_EN to make the first mismatching store fail the run at once.
module mem_write_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 4,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic reset,
  mem_write_checker_if.slave bus
);
  localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1;
  localparam int PTR_W = $clog2(N_EXP + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} StateT;

  StateT             state, nextState;
  logic [ADDR_W-1:0] tableAddr [N_EXP];
  logic [DATA_W-1:0] tableData [N_EXP];
  logic [N_EXP-1:0]  hit;
  logic [PTR_W-1:0]  ptr;
  logic [TMR_W-1:0]  timer;
  logic              orderedMode;
  logic [CNT_W-1:0]  matchCnt, mismatchCnt;
  logic [ADDR_W-1:0] badAddr;
  logic [DATA_W-1:0] badData;
  logic              timedOut;

  logic [N_EXP-1:0]  addrDataEq, ptrSel, freeEq, lowestFree;
  logic              isMatch, isMismatch, completes, timerDone, strictFail, timeoutFail;

  // Match evaluation; lowestFree isolates the lowest unhit matching entry
  always_comb begin
    addrDataEq = '0;
    ptrSel     = '0;
    for (int i = 0; i < N_EXP; i++) begin
      addrDataEq[i] = (bus.mem_addr == tableAddr[i]) && (bus.mem_wdata == tableData[i]);
      ptrSel[i]     = (ptr == PTR_W'(i));
    end
    freeEq     = addrDataEq & ~hit;
    lowestFree = freeEq & (~freeEq + N_EXP'(1));
    isMatch    = bus.mem_we && (orderedMode ? (|(addrDataEq & ptrSel)) : (|freeEq));
    isMismatch = bus.mem_we && !isMatch;
    completes  = isMatch && (orderedMode ? (ptr == PTR_W'(N_EXP - 1)) : (&(hit | lowestFree)));
    timerDone  = (timer == TMR_W'(TIMEOUT - 1));
`ifdef CHECKER_STRICT_EN
    strictFail = isMismatch;
`else
    strictFail = 1'b0;
`endif
    timeoutFail = timerDone && !completes && !strictFail;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // A completing match beats both a simultaneous timeout and any fail cause
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (bus.start) nextState = RUN;
      RUN: begin
        if (completes)                       nextState = PASS;
        else if (strictFail || timeoutFail)  nextState = FAIL;
      end
      PASS, FAIL: if (bus.clear) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_EXP; i++) begin
        tableAddr[i] <= '0;
        tableData[i] <= '0;
      end
      hit         <= '0;
      ptr         <= '0;
      timer       <= '0;
      orderedMode <= 1'b0;
      matchCnt    <= '0;
      mismatchCnt <= '0;
      badAddr     <= '0;
      badData     <= '0;
      timedOut    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < N_EXP; i++) begin
            if (bus.exp_we && (bus.exp_idx == IDX_W'(i))) begin
              tableAddr[i] <= bus.exp_addr;
              tableData[i] <= bus.exp_data;
            end
          end
          if (bus.start) begin
            hit         <= '0;
            ptr         <= '0;
            timer       <= '0;
            orderedMode <= bus.ordered;
            matchCnt    <= '0;
            mismatchCnt <= '0;
            badAddr     <= '0;
            badData     <= '0;
            timedOut    <= 1'b0;
          end
        end
        RUN: begin
          timer <= timer + 1'b1;
          if (isMatch) begin
            if (orderedMode) ptr <= ptr + 1'b1;
            else             hit <= hit | lowestFree;
            if (matchCnt != '1) matchCnt <= matchCnt + 1'b1;
          end
          if (isMismatch) begin
            if (mismatchCnt != '1) mismatchCnt <= mismatchCnt + 1'b1;
            badAddr <= bus.mem_addr;
            badData <= bus.mem_wdata;
          end
          timedOut <= timeoutFail;
        end
        PASS, FAIL: if (bus.clear) timedOut <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state == RUN);
  assign bus.pass         = (state == PASS);
  assign bus.fail         = (state == FAIL);
  assign bus.timed_out    = timedOut;
  assign bus.match_cnt    = matchCnt;
  assign bus.mismatch_cnt = mismatchCnt;
  assign bus.bad_addr     = badAddr;
  assign bus.bad_data     = badData;
endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the checker.
module tb_mem_write_checker;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int N_EXP   = 2;
  localparam int TIMEOUT = 50;
  localparam int CNT_W   = 3;
  localparam int IDX_W   = (N_EXP > 1) ? $clog2(N_EXP) : 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CHECKER_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk;
  logic reset;

  mem_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_EXP(N_EXP), .CNT_W(CNT_W)) bus ();

  mem_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_EXP(N_EXP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: expected table, which entries are consumed, run verdict
  logic [ADDR_W-1:0] mAddr [N_EXP];
  logic [DATA_W-1:0] mData [N_EXP];
  bit                mUsed [N_EXP];
  bit                mRunning, mPassed, mFailed, mTimedOut, mOrdered;
  int                mNext, mElapsed, mMatches, mMismatches;
  logic [ADDR_W-1:0] mBadAddr;
  logic [DATA_W-1:0] mBadData;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic int satCnt(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N_EXP; i++) begin
      mAddr[i] = '0;
      mData[i] = '0;
      mUsed[i] = 1'b0;
    end
    mRunning = 0; mPassed = 0; mFailed = 0; mTimedOut = 0; mOrdered = 0;
    mNext = 0; mElapsed = 0; mMatches = 0; mMismatches = 0;
    mBadAddr = '0; mBadData = '0;
  endtask

  task automatic modelStep();
    bit matched, mismatch;
    int done;
    if (mRunning) begin
      matched  = 0;
      mismatch = 0;
      if (bus.mem_we) begin
        if (mOrdered) begin
          if (bus.mem_addr == mAddr[mNext] && bus.mem_wdata == mData[mNext]) begin
            matched = 1;
            mNext++;
          end
        end else begin
          for (int i = 0; i < N_EXP; i++) begin
            if (!matched && !mUsed[i] && bus.mem_addr == mAddr[i] && bus.mem_wdata == mData[i]) begin
              mUsed[i] = 1;
              matched  = 1;
            end
          end
        end
        if (matched) mMatches++;
        else begin
          mismatch = 1;
          mMismatches++;
          mBadAddr = bus.mem_addr;
          mBadData = bus.mem_wdata;
        end
      end
      mElapsed++;
      done = 0;
      if (mOrdered) done = mNext;
      else for (int i = 0; i < N_EXP; i++) done += int'(mUsed[i]);
      if (done == N_EXP) begin
        mRunning = 0; mPassed = 1;
      end else if (STRICT && mismatch) begin
        mRunning = 0; mFailed = 1;
      end else if (mElapsed == TIMEOUT) begin
        mRunning = 0; mFailed = 1; mTimedOut = 1;
      end
    end else if (mPassed || mFailed) begin
      if (bus.clear) begin
        mPassed = 0; mFailed = 0; mTimedOut = 0;
      end
    end else begin
      if (bus.exp_we) begin
        mAddr[bus.exp_idx] = bus.exp_addr;
        mData[bus.exp_idx] = bus.exp_data;
      end
      if (bus.start) begin
        mRunning = 1; mOrdered = bus.ordered;
        mNext = 0; mElapsed = 0; mMatches = 0; mMismatches = 0;
        mBadAddr = '0; mBadData = '0; mTimedOut = 0;
        for (int i = 0; i < N_EXP; i++) mUsed[i] = 1'b0;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "/busy"},         64'(bus.busy),         64'(mRunning));
    checkOutput({tag, "/pass"},         64'(bus.pass),         64'(mPassed));
    checkOutput({tag, "/fail"},         64'(bus.fail),         64'(mFailed));
    checkOutput({tag, "/timed_out"},    64'(bus.timed_out),    64'(mTimedOut));
    checkOutput({tag, "/match_cnt"},    64'(bus.match_cnt),    64'(satCnt(mMatches)));
    checkOutput({tag, "/mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'(satCnt(mMismatches)));
    checkOutput({tag, "/bad_addr"},     64'(bus.bad_addr),     64'(mBadAddr));
    checkOutput({tag, "/bad_data"},     64'(bus.bad_data),     64'(mBadData));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    compareAll(tag);
  endtask

  task automatic idleInputs();
    bus.exp_we = 0; bus.exp_idx = '0; bus.exp_addr = '0; bus.exp_data = '0;
    bus.ordered = 0; bus.start = 0; bus.clear = 0;
    bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask

  task automatic loadEntry(input int idx, input int a, input int d);
    bus.exp_we = 1; bus.exp_idx = IDX_W'(idx);
    bus.exp_addr = ADDR_W'(a); bus.exp_data = DATA_W'(d);
    cycle("load");
    bus.exp_we = 0;
  endtask

  task automatic pulseStart(input bit ord);
    bus.ordered = ord; bus.start = 1;
    cycle("start");
    bus.start = 0;
  endtask

  task automatic pulseClear();
    bus.clear = 1;
    cycle("clear");
    bus.clear = 0;
  endtask

  task automatic applyStimulus(input bit we, input int a, input int d);
    bus.mem_we = we; bus.mem_addr = ADDR_W'(a); bus.mem_wdata = DATA_W'(d);
    cycle("store");
    bus.mem_we = 0;
  endtask

  task automatic waitVerdict(input string tag, input int budget, output int used);
    used = 0;
    while (!(bus.pass || bus.fail) && used < budget) begin
      applyStimulus(0, 0, 0);
      used++;
    end
    checkOutput({tag, "/verdictSeen"}, 64'(bus.pass || bus.fail), 64'd1);
  endtask

  task automatic pulseAsyncReset(input string tag);
    reset = 1'b0;
    #2;
    modelReset();
    compareAll(tag);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int used;
    int k;
    idleInputs();
    reset = 1'b0;
    modelReset();
    #8;
    compareAll("reset");
    reset = 1'b1;

    // Out-of-order stores in ordered mode, then the same stores unordered
    loadEntry(0, 100, 7);
    loadEntry(1, 104, 25);
    pulseStart(1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 104, 25);
    checkOutput("ordMis/mismatch_cnt", 64'(bus.mismatch_cnt), 64'd1);
    checkOutput("ordMis/bad_addr", 64'(bus.bad_addr), 64'd104);
    checkOutput("ordMis/bad_data", 64'(bus.bad_data), 64'd25);
    applyStimulus(1, 100, 7);
    waitVerdict("ordMis", 200, used);
    checkOutput("ordMis/fail", 64'(bus.fail), 64'd1);
    checkOutput("ordMis/timed_out", 64'(bus.timed_out), STRICT ? 64'd0 : 64'd1);
    checkOutput("ordMis/match_cnt", 64'(bus.match_cnt), STRICT ? 64'd0 : 64'd1);
    pulseClear();
    pulseStart(0);
    applyStimulus(1, 104, 25);
    applyStimulus(1, 100, 7);
    checkOutput("unord/pass", 64'(bus.pass), 64'd1);
    checkOutput("unord/match_cnt", 64'(bus.match_cnt), 64'd2);

    // Pure timeout: verdict lands exactly TIMEOUT cycles after the start edge
    pulseClear();
    pulseStart(1);
    waitVerdict("tmo", 200, used);
    checkOutput("tmo/latency", 64'(used), 64'(TIMEOUT));
    checkOutput("tmo/timed_out", 64'(bus.timed_out), 64'd1);
    checkOutput("tmo/match_cnt", 64'(bus.match_cnt), 64'd0);

    // Wrong data followed by the right store
    pulseClear();
    loadEntry(0, 104, 25);
    loadEntry(1, 200, 3);
    pulseStart(1);
    applyStimulus(1, 104, 24);
    checkOutput("strict/fail", 64'(bus.fail), 64'(STRICT));
    applyStimulus(1, 104, 25);
    applyStimulus(1, 200, 3);
    checkOutput("badData/pass", 64'(bus.pass), 64'(!STRICT));
    checkOutput("badData/mismatch_cnt", 64'(bus.mismatch_cnt), 64'd1);
    checkOutput("badData/bad_data", 64'(bus.bad_data), 64'd24);
    checkOutput("badData/timed_out", 64'(bus.timed_out), 64'd0);

    // Duplicate entries consumed one per store; third store lands after PASS
    pulseClear();
    loadEntry(0, 8, 1);
    loadEntry(1, 8, 1);
    pulseStart(0);
    applyStimulus(1, 8, 1);
    checkOutput("dup/busyAfterOne", 64'(bus.busy), 64'd1);
    applyStimulus(1, 8, 1);
    applyStimulus(1, 8, 1);
    checkOutput("dup/pass", 64'(bus.pass), 64'd1);
    checkOutput("dup/match_cnt", 64'(bus.match_cnt), 64'd2);
    checkOutput("dup/mismatch_cnt", 64'(bus.mismatch_cnt), 64'd0);

    // Asynchronous reset mid-run wipes the table; zeros then match
    pulseClear();
    loadEntry(0, 100, 7);
    loadEntry(1, 104, 25);
    pulseStart(1);
    applyStimulus(1, 100, 7);
    pulseAsyncReset("midRunReset");
    checkOutput("midRunReset/busy", 64'(bus.busy), 64'd0);
    checkOutput("midRunReset/match_cnt", 64'(bus.match_cnt), 64'd0);
    pulseStart(1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("zeroTable/pass", 64'(bus.pass), 64'd1);
    pulseClear();

    // Random traffic over a small address/data space so matches are frequent
    for (int n = 0; n < 3000; n++) begin
      bus.exp_we   = ($urandom_range(0, 3) == 0);
      bus.exp_idx  = IDX_W'($urandom_range(0, N_EXP - 1));
      bus.exp_addr = ADDR_W'(4 * $urandom_range(0, 2));
      bus.exp_data = DATA_W'($urandom_range(0, 2));
      bus.ordered  = 1'($urandom_range(0, 1));
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.clear    = ($urandom_range(0, 7) == 0);
      bus.mem_we   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, N_EXP - 1);
        bus.mem_addr  = mAddr[k];
        bus.mem_wdata = mData[k];
      end else begin
        bus.mem_addr  = ADDR_W'(4 * $urandom_range(0, 2));
        bus.mem_wdata = DATA_W'($urandom_range(0, 2));
      end
      cycle("rand");
      if ($urandom_range(0, 399) == 0) pulseAsyncReset("randReset");
    end

    idleInputs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
